// File: rtl/rtc_ctrl_pkg.sv
// Shared definitions for the RTC control sequencer: state encoding and default timing.
package rtc_ctrl_pkg;

  localparam int ST_W         = 3;
  localparam int POLL_DIV_DEF = 16;
  localparam int TO_LIMIT_DEF = 200;

  typedef enum logic [ST_W-1:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_READ  = 3'd2,
    ST_CHK   = 3'd3,
    ST_WRITE = 3'd4,
    ST_USER  = 3'd5
  } state_t;

  // Phases that wait on a sub-FSM and so are guarded by the watchdog.
  function automatic logic is_watched(input state_t st);
    return (st == ST_INIT) || (st == ST_READ) || (st == ST_WRITE);
  endfunction

endpackage

// File: rtl/rtc_prio_sel.sv
// Fixed-priority one-hot encoder: grants the lowest-index asserted request.
module rtc_prio_sel #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  // seen[i] is high when any request below index i is asserted.
  logic [N-1:0] seen;

  assign seen[0] = 1'b0;

  for (genvar gi = 0; gi < N; gi++) begin : g_grant
    assign grant[gi] = req[gi] & ~seen[gi];
    if (gi < N - 1) begin : g_chain
      assign seen[gi+1] = seen[gi] | req[gi];
    end
  end

endmodule

// File: rtl/rtc_main_sequencer.sv
// RTC top-level sequencer: init, periodic read-back, and arbitration of user
// requests into write/user-edit phases, with a per-phase watchdog.
module rtc_main_sequencer
  import rtc_ctrl_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int POLL_DIV = POLL_DIV_DEF,
  parameter int TO_W     = 8,
  parameter int TO_LIMIT = TO_LIMIT_DEF
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             fin_init,
  input  logic             fin_read,
  input  logic             fin_write,
  input  logic             fin_user,
  input  logic [N_REQ-1:0] req,
  output logic             start_init,
  output logic             start_read,
  output logic             start_write,
  output logic             user_mode,
  output logic [N_REQ-1:0] sel,
  output logic             busy,
  output logic             timeout_err,
  output logic [ST_W-1:0]  state_dbg
);

  localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  state_t           state_reg, state_next;
  logic             entry_reg;
  logic [PW-1:0]    poll_reg;
  logic [TO_W-1:0]  wd_reg;
  logic [N_REQ-1:0] sel_reg;
  logic             err_reg;
  logic             start_init_reg, start_read_reg, start_write_reg;

  logic [N_REQ-1:0] grant;
  logic             fin_cur;
  logic             wd_expire;
  logic             entering;

  rtc_prio_sel #(.N(N_REQ)) u_prio (
    .req   (req),
    .grant (grant)
  );

  always_comb begin
    fin_cur = 1'b0;
    case (state_reg)
      ST_INIT:  fin_cur = fin_init;
      ST_READ:  fin_cur = fin_read;
      ST_WRITE: fin_cur = fin_write;
      default:  fin_cur = 1'b0;
    endcase
  end

  // A done flag arriving in the final allowed cycle beats the timeout.
  assign wd_expire = !entry_reg && is_watched(state_reg) && !fin_cur &&
                     (wd_reg == TO_W'(TO_LIMIT - 1));

  always_comb begin
    state_next = state_reg;
    if (!entry_reg) begin
      case (state_reg)
        ST_INIT:  if (fin_init) state_next = ST_IDLE;
        ST_IDLE:  if (poll_reg == PW'(POLL_DIV - 1)) state_next = ST_READ;
        ST_READ:  if (fin_read) state_next = ST_CHK;
                  else if (wd_expire) state_next = ST_INIT;
        ST_CHK:   state_next = (|req) ? ST_WRITE : ST_IDLE;
        ST_WRITE: if (fin_write) state_next = ST_USER;
                  else if (wd_expire) state_next = ST_INIT;
        ST_USER:  if (fin_user || !(|(req & sel_reg))) state_next = ST_IDLE;
        default:  state_next = ST_INIT;
      endcase
    end
  end

  // The post-reset entry flag and an INIT timeout both count as entries
  // even though the state encoding does not change.
  assign entering = entry_reg || wd_expire || (state_next != state_reg);

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_reg       <= ST_INIT;
      entry_reg       <= 1'b1;
      poll_reg        <= '0;
      wd_reg          <= '0;
      sel_reg         <= '0;
      err_reg         <= 1'b0;
      start_init_reg  <= 1'b0;
      start_read_reg  <= 1'b0;
      start_write_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      entry_reg       <= 1'b0;
      start_init_reg  <= entering && (state_next == ST_INIT);
      start_read_reg  <= entering && (state_next == ST_READ);
      start_write_reg <= entering && (state_next == ST_WRITE);

      if (entering || state_reg != ST_IDLE) poll_reg <= '0;
      else                                   poll_reg <= poll_reg + PW'(1);

      if (entering || !is_watched(state_reg)) wd_reg <= '0;
      else                                    wd_reg <= wd_reg + TO_W'(1);

      if (state_reg == ST_CHK)
        sel_reg <= grant;
      else if (state_next == ST_INIT || state_next == ST_IDLE)
        sel_reg <= '0;

      if (wd_expire) err_reg <= 1'b1;
    end
  end

  assign start_init  = start_init_reg;
  assign start_read  = start_read_reg;
  assign start_write = start_write_reg;
  assign user_mode   = (state_reg == ST_USER);
  assign sel         = sel_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign timeout_err = err_reg;
  assign state_dbg   = state_reg;

endmodule

// File: tb/tb_rtc_main_sequencer.sv
// Directed bench for rtc_main_sequencer with a cycle-level phase/age reference model.
module tb_rtc_main_sequencer;

  localparam int N_REQ    = 3;
  localparam int POLL_DIV = 16;
  localparam int TO_LIMIT = 200;

  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             fin_init = 1'b0, fin_read = 1'b0, fin_write = 1'b0, fin_user = 1'b0;
  logic [N_REQ-1:0] req = '0;
  logic             start_init, start_read, start_write, user_mode, busy, timeout_err;
  logic [N_REQ-1:0] sel;
  logic [2:0]       state_dbg;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 CLK = ~CLK;

  rtc_main_sequencer #(
    .N_REQ(N_REQ), .POLL_DIV(POLL_DIV), .TO_W(8), .TO_LIMIT(TO_LIMIT)
  ) dut (
    .CLK(CLK), .reset(reset),
    .fin_init(fin_init), .fin_read(fin_read), .fin_write(fin_write), .fin_user(fin_user),
    .req(req),
    .start_init(start_init), .start_read(start_read), .start_write(start_write),
    .user_mode(user_mode), .sel(sel), .busy(busy), .timeout_err(timeout_err),
    .state_dbg(state_dbg)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: phase number plus age (cycles since entry, -1 = held by reset).
  int               m_phase = 0;
  int               m_age   = -1;
  logic [N_REQ-1:0] m_sel   = '0;
  logic             m_err   = 1'b0;
  bit               m_valid = 1'b0;

  always @(posedge CLK) begin : model
    int nxt;
    bit reenter;
    logic [N_REQ-1:0] g;
    if (reset) begin
      m_phase = 0; m_age = -1; m_sel = '0; m_err = 1'b0; m_valid = 1'b1;
    end else if (m_age < 0) begin
      m_age = 0;
    end else begin
      nxt = m_phase;
      reenter = 1'b0;
      case (m_phase)
        0: if (fin_init) nxt = 1;
           else if (m_age + 1 == TO_LIMIT) begin m_err = 1'b1; reenter = 1'b1; end
        1: if (m_age + 1 == POLL_DIV) nxt = 2;
        2: if (fin_read) nxt = 3;
           else if (m_age + 1 == TO_LIMIT) begin m_err = 1'b1; m_sel = '0; nxt = 0; end
        3: begin
             g = '0;
             for (int i = N_REQ - 1; i >= 0; i--) if (req[i]) g = N_REQ'(1) << i;
             m_sel = g;
             nxt = (g != '0) ? 4 : 1;
           end
        4: if (fin_write) nxt = 5;
           else if (m_age + 1 == TO_LIMIT) begin m_err = 1'b1; m_sel = '0; nxt = 0; end
        5: if (fin_user || (req & m_sel) == '0) begin nxt = 1; m_sel = '0; end
        default: nxt = 0;
      endcase
      if (nxt != m_phase || reenter) begin m_phase = nxt; m_age = 0; end
      else m_age++;
    end
  end

  always @(posedge CLK) begin : compare
    #1;
    if (m_valid) begin
      chk("state_dbg",   32'(state_dbg),   32'(m_phase));
      chk("start_init",  32'(start_init),  32'(m_phase == 0 && m_age == 0));
      chk("start_read",  32'(start_read),  32'(m_phase == 2 && m_age == 0));
      chk("start_write", 32'(start_write), 32'(m_phase == 4 && m_age == 0));
      chk("user_mode",   32'(user_mode),   32'(m_phase == 5));
      chk("busy",        32'(busy),        32'(m_phase != 1));
      chk("sel",         32'(sel),         32'(m_sel));
      chk("timeout_err", 32'(timeout_err), 32'(m_err));
    end
  end

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget);
    int k = 0;
    do begin step(); k++; end while (state_dbg != st && k < budget);
    if (state_dbg != st) chk("wait_state_bound", 32'(state_dbg), 32'(st));
  endtask

  task automatic pulse_fin_init();
    @(negedge CLK) fin_init = 1'b1;
    step();
    @(negedge CLK) fin_init = 1'b0;
  endtask

  initial begin : directed
    int n;
    repeat (3) @(posedge CLK);
    #1;
    chk("t0_rst_state", 32'(state_dbg), 0);
    chk("t0_rst_sel", 32'(sel), 0);
    chk("t0_rst_start_init", 32'(start_init), 0);
    @(negedge CLK) reset = 1'b0;
    step();
    chk("t1_start_init", 32'(start_init), 1);
    step();
    chk("t1_start_init_once", 32'(start_init), 0);
    @(negedge CLK) fin_init = 1'b1;
    step();
    chk("t1_idle", 32'(state_dbg), 1);
    @(negedge CLK) fin_init = 1'b0;
    n = 0;
    do begin step(); n++; end while (state_dbg != 3'd2 && n < 40);
    chk("t1_read_delay", 32'(n), 16);
    chk("t1_start_read", 32'(start_read), 1);
    $display("test1: reset/init/poll, read after %0d idle cycles", n);

    @(negedge CLK) fin_read = 1'b1;
    step();
    chk("t2_chk", 32'(state_dbg), 3);
    @(negedge CLK) fin_read = 1'b0;
    step();
    chk("t2_idle", 32'(state_dbg), 1);
    chk("t2_sel", 32'(sel), 0);
    chk("t2_busy", 32'(busy), 0);
    $display("test2: read with no request returns to idle");

    wait_state(3'd2, 40);
    @(negedge CLK) begin req = 3'b110; fin_read = 1'b1; end
    step();
    chk("t3_chk", 32'(state_dbg), 3);
    @(negedge CLK) fin_read = 1'b0;
    step();
    chk("t3_write", 32'(state_dbg), 4);
    chk("t3_sel", 32'(sel), 32'b010);
    chk("t3_start_write", 32'(start_write), 1);
    @(negedge CLK) fin_write = 1'b1;
    step();
    chk("t3_user_mode", 32'(user_mode), 1);
    @(negedge CLK) fin_write = 1'b0;
    step();
    chk("t3_user_hold", 32'(user_mode), 1);
    @(negedge CLK) req = 3'b100;
    step();
    chk("t3_drop_idle", 32'(state_dbg), 1);
    chk("t3_drop_sel", 32'(sel), 0);
    $display("test3: grant 010, write, user, exit on request drop");

    @(negedge CLK) req = 3'b010;
    wait_state(3'd2, 40);
    @(negedge CLK) fin_read = 1'b1;
    step();
    @(negedge CLK) fin_read = 1'b0;
    wait_state(3'd4, 4);
    @(negedge CLK) fin_write = 1'b1;
    step();
    @(negedge CLK) begin fin_write = 1'b0; req = 3'b011; end
    repeat (2) step();
    chk("t4_user", 32'(state_dbg), 5);
    chk("t4_sel_kept", 32'(sel), 32'b010);
    @(negedge CLK) fin_user = 1'b1;
    step();
    chk("t4_idle", 32'(state_dbg), 1);
    chk("t4_sel_clr", 32'(sel), 0);
    @(negedge CLK) begin fin_user = 1'b0; req = '0; end
    $display("test4: higher-priority request during user phase ignored");

    wait_state(3'd2, 40);
    n = 1;
    while (state_dbg == 3'd2 && n < 300) begin
      step();
      if (state_dbg == 3'd2) n++;
    end
    chk("t5_read_cycles", 32'(n), 200);
    chk("t5_err", 32'(timeout_err), 1);
    chk("t5_init", 32'(state_dbg), 0);
    chk("t5_start_init", 32'(start_init), 1);
    pulse_fin_init();
    step();
    chk("t5_err_sticky", 32'(timeout_err), 1);
    $display("test5a: read timeout after %0d cycles", n);

    @(negedge CLK) req = 3'b001;
    wait_state(3'd2, 40);
    @(negedge CLK) fin_read = 1'b1;
    step();
    @(negedge CLK) fin_read = 1'b0;
    wait_state(3'd4, 4);
    chk("t6_sel_before", 32'(sel), 32'b001);
    @(negedge CLK) reset = 1'b1;
    step();
    chk("t6_state", 32'(state_dbg), 0);
    chk("t6_sel", 32'(sel), 0);
    chk("t6_err", 32'(timeout_err), 0);
    @(negedge CLK) begin reset = 1'b0; req = '0; end
    step();
    pulse_fin_init();
    $display("test6: reset during write aborts the phase");

    wait_state(3'd2, 40);
    repeat (200) @(negedge CLK);
    fin_read = 1'b1;
    step();
    chk("t5b_chk", 32'(state_dbg), 3);
    chk("t5b_no_err", 32'(timeout_err), 0);
    @(negedge CLK) fin_read = 1'b0;
    step();
    chk("t5b_idle", 32'(state_dbg), 1);
    $display("test5b: done flag in the final watchdog cycle wins");

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : time_guard
    #200000;
    $display("FAIL time_guard: simulation exceeded %0t", $time);
    $fatal(1, "time limit");
  end

endmodule
